sram_like_responder: RTL and testbench
======================================

Name: sram_like_responder

Overview:
- Memory-side responder for the SRAM-like request/response interface driven by the CPU's instruction and data ports: req/wr/size/addr/wstrb/wdata in, addr_ok/data_ok/rdata out.
- Holds an internal word-addressed memory and queues accepted requests in an in-order FIFO.
- Returns data_ok after a configurable latency.
- Used as the bench and FPGA stand-in memory for the exp14+ CPU.

Parameters:
- ADDR_W, 10, word-index width; memory depth is 2^ADDR_W words.
- LATENCY, 2, cycles from acceptance to data_ok for an entry at queue head; legal range 1..15.
- OUTSTANDING, 2, request FIFO depth; legal range 1..8.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  1  request valid.
- wr  in  1  1=write, 0=read.
- size  in  2  0=byte, 1=half, 2=word; carried only, not used for the memory access.
- addr  in  32  byte address.
- wstrb  in  4  byte write enables; used only when wr=1.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req is high.
- data_ok  out  1  response for the oldest outstanding request.
- rdata  out  32  read word; valid only when data_ok=1 for a read.

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low.
- Reset values: FIFO emptied, head counter cleared, addr_ok=1, data_ok=0, rdata=0.
  - Memory array is NOT reset; contents survive reset.
  - Reset asserted mid-operation drops all outstanding entries; no data_ok for them.
- Acceptance: addr_ok = ~full. This is registered-state-derived, does not depend on req, and has no same-cycle pop bypass.
  - Handshake occurs when req & addr_ok at a rising edge.
- Memory indexing: index = addr[ADDR_W+1:2]. Upper address bits alias; addr[1:0] is ignored.
- Write handshake: memory bytes with wstrb[i]=1 take wdata[8i+7:8i] at that same edge. The entry is enqueued with wr=1.
  - wstrb=0 is a legal no-op write and still gets a data_ok.
- Read handshake: the full memory word is captured into the entry at the acceptance edge, seeing all earlier-accepted writes.
  - A write accepted later never alters an earlier read's data.
  - No byte extraction is done; the initiator aligns the data.
- Head counter:
  - Loaded with LATENCY-1 when an entry becomes head, either by push into an empty FIFO or by a pop that leaves the FIFO non-empty.
  - Decrements each cycle while non-zero.
- Response: data_ok = ~empty & (cnt==0). rdata = head read data when the head entry is a read, else 0.
  - Response and rdata are combinational from registers.
  - data_ok has no back-pressure; the entry pops on the same edge.
- Latency: with LATENCY=L and an empty FIFO, a request accepted at the end of cycle k gets data_ok in cycle k+L.
  - Back-to-back responses are spaced L cycles apart, because each new head reloads the counter.
- Simultaneous push and pop: legal. Count is unchanged. A pushed entry that becomes head immediately (count was 1) loads the counter.
- Full FIFO: addr_ok=0 in every cycle count==OUTSTANDING, including a cycle where a pop also occurs. It reasserts the cycle after the pop.
- Pointers: wrap modulo OUTSTANDING; count width is $clog2(OUTSTANDING+1).
- Responses are strictly in acceptance order.

Optional Feature:
- Macro: SRAM_RSP_RAND_DELAY_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every cycle.
  - On each head load, the counter is loaded with LATENCY-1 + lfsr[1:0], giving 0..3 extra cycles.
  - addr_ok is additionally forced to 0 in cycles where lfsr[4:2]==3'b111.
- Undefined: no LFSR, fixed timing exactly as above.

Decomposition:
- Shared header (alongside macro.vh):
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings.
  - The FIFO entry layout macro: {wr, rdata[31:0]}, 33 bits.
  - The LFSR seed constant.
- One sub-module, sram_rsp_fifo: parameterised depth/width, sync push/pop, full/empty/count, async active-low reset.
- The memory array and head counter stay in the top.

Test Plan:
- Single write then read (LATENCY=2): write addr=0x40, wstrb=4'hF, wdata=0xDEADBEEF; then read 0x40.
  - Required: data_ok 2 cycles after each acceptance, read rdata=0xDEADBEEF.
- Byte strobes: word 0x80=0x11223344, write wstrb=4'b0100 wdata=0x00AA0000; read.
  - Required: rdata=0x11AA3344.
- Fill (OUTSTANDING=2, req held high): first two requests get addr_ok=1; addr_ok=0 while count=2.
  - Required: addr_ok returns 1 the cycle after the first data_ok; responses arrive in order.
- Read-before-write ordering: read 0x100 (holds 0x5), then write 0x100=0x9 accepted next cycle.
  - Required: read returns 0x5; a subsequent read returns 0x9.
- Reset mid-flight: two requests outstanding, pulse resetn low for 1 cycle.
  - Required: data_ok never asserts for them, addr_ok=1 immediately, memory value at 0x40 still 0xDEADBEEF.
- Alias: with ADDR_W=10, write 0x1004=0x77, read 0x0004.
  - Required: rdata=0x77. Repeat with SRAM_RSP_RAND_DELAY_EN defined; data_ok latency must stay within 2..5.

Source files
------------

// File: rtl/sram_like_responder_pkg.sv
// Shared encodings, FIFO entry layout and LFSR seed for the SRAM-like responder.
package sram_like_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int ENTRY_W = 33;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Queue entry: {wr, rdata}; rdata is zero for writes.
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order request FIFO with synchronous push/pop and full/empty/count flags.
module sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side SRAM-like responder: word memory, in-order request queue, fixed head latency.
// Optional SRAM_RSP_RAND_DELAY_EN adds LFSR-driven extra latency and addr_ok stalls.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int TMR_W = 5;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              hs;
    logic              head_load;
    logic [TMR_W-1:0]  head_cnt;
    logic [TMR_W-1:0]  load_val;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    entry_t            push_entry;
    entry_t            head;
    logic              unused_bits;

    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};
    assign idx         = addr[ADDR_W+1:2];
    assign hs          = req & addr_ok;

    assign push_entry.wr    = wr;
    assign push_entry.rdata = wr ? 32'h0 : mem[idx];

    sram_rsp_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .pop    (data_ok),
        .din    (push_entry),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (hs && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef SRAM_RSP_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign load_val = TMR_W'(LATENCY - 1) + TMR_W'(lfsr[1:0]);
    assign addr_ok  = ~full & ~(lfsr[4:2] == 3'b111);
`else
    assign load_val = TMR_W'(LATENCY - 1);
    assign addr_ok  = ~full;
`endif

    // A new head appears on push into empty, or on a pop that leaves entries behind.
    assign head_load = (hs & empty) | (data_ok & ((count > CNT_W'(1)) | hs));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              head_cnt <= '0;
        else if (head_load)       head_cnt <= load_val;
        else if (head_cnt != '0)  head_cnt <= head_cnt - 1'b1;
    end

    assign data_ok = ~empty & (head_cnt == '0);
    assign rdata   = (~empty & ~head.wr) ? head.rdata : 32'h0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Self-checking bench for sram_like_responder against a queue/array reference model.
module tb_sram_like_responder;

    localparam int L   = 2;
    localparam int OUT = 2;
    localparam int AW  = 10;
`ifdef SRAM_RSP_RAND_DELAY_EN
    localparam int LAT_MAX = L + 3;
`else
    localparam int LAT_MAX = L;
`endif

    logic        clk, resetn, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok;

    sram_like_responder #(.ADDR_W(AW), .LATENCY(L), .OUTSTANDING(OUT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit wr; logic [31:0] data; } ent_t;

    int          checks, errors, cyc, head_start, smp_cyc, hs_cyc;
    ent_t        q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] resp_q[$];
    int          resp_at[$];
    bit          exp_aok, exp_dok, exp_is_rd, hs;
    logic        obs_aok, obs_dok;
    logic [31:0] obs_rdata, exp_rdata;

    // One clock of stimulus; the model is updated from the spec's rules at the edge.
    task automatic run_cycle(input bit r, input bit w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d);
        int idx;
        ent_t e;
        logic [31:0] tmp;
        req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
        @(negedge clk);
        smp_cyc   = cyc;
        obs_aok   = addr_ok;
        obs_dok   = data_ok;
        obs_rdata = rdata;
        exp_aok   = q.size() < OUT;
        exp_dok   = (q.size() > 0) && (cyc == head_start + L);
`ifdef SRAM_RSP_RAND_DELAY_EN
        exp_aok = exp_aok && obs_aok;
        exp_dok = (q.size() > 0) && (cyc >= head_start + L) && ((cyc >= head_start + L + 3) || obs_dok);
`endif
        exp_is_rd = exp_dok && !q[0].wr;
        exp_rdata = exp_is_rd ? q[0].data : 32'h0;
        if (obs_dok) begin
            resp_q.push_back(obs_rdata);
            resp_at.push_back(cyc);
        end
        hs = r && exp_aok;
        @(posedge clk);
        if (exp_dok) begin
            void'(q.pop_front());
            if (q.size() > 0) head_start = cyc;
        end
        if (hs) begin
            idx = int'((a >> 2) % (32'd1 << AW));
            if (w) begin
                tmp = ref_mem.exists(idx) ? ref_mem[idx] : 32'hx;
                for (int b = 0; b < 4; b++)
                    if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
                ref_mem[idx] = tmp;
                e.wr = 1'b1; e.data = 32'h0;
            end else begin
                e.wr = 1'b0;
                e.data = ref_mem.exists(idx) ? ref_mem[idx] : 32'hx;
            end
            hs_cyc = cyc;
            if (q.size() == 0) head_start = cyc;
            q.push_back(e);
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output bit ok, output int acc);
        ok = 0; acc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            run_cycle(1'b1, w, a, s, d);
            if (hs) begin ok = 1; acc = hs_cyc; end
        end
        req = 1'b0;
    endtask

    task automatic wait_resp(output bit found, output int at, output logic [31:0] data);
        found = 0; at = 0; data = 32'h0;
        for (int i = 0; i < 30 && resp_q.size() == 0; i++) run_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        if (resp_q.size() > 0) begin
            found = 1;
            data  = resp_q.pop_front();
            at    = resp_at.pop_front();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0; size = '0;
        #3;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL reset_addr_ok got=%b exp=1", addr_ok); end
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got=%b exp=0", data_ok); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        @(posedge clk); #1;
        resetn = 1'b1;
        q.delete(); resp_q.delete(); resp_at.delete();
        cyc = 0; head_start = 0;
    endtask

    task automatic test_write_read();
        bit ok, f; int acc, at; logic [31:0] d;
        issue(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, ok, acc);
        wait_resp(f, at, d);
        checks++; if (!ok || !f || at - acc < L || at - acc > LAT_MAX) begin
            errors++; $display("FAIL wr_latency got=%0d exp=%0d found=%0d", at - acc, L, f); end
        issue(1'b0, 32'h40, 4'h0, 32'h0, ok, acc);
        wait_resp(f, at, d);
        checks++; if (!ok || !f || at - acc < L || at - acc > LAT_MAX) begin
            errors++; $display("FAIL rd_latency got=%0d exp=%0d found=%0d", at - acc, L, f); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    endtask

    task automatic test_byte_strobe();
        bit ok, f; int acc, at; logic [31:0] d;
        issue(1'b1, 32'h80, 4'hF, 32'h11223344, ok, acc); wait_resp(f, at, d);
        issue(1'b1, 32'h80, 4'b0100, 32'h00AA0000, ok, acc); wait_resp(f, at, d);
        checks++; if (!f || d !== 32'h0) begin errors++; $display("FAIL strobe_wr_rdata got=%h exp=0 found=%0d", d, f); end
        issue(1'b0, 32'h80, 4'h0, 32'h0, ok, acc); wait_resp(f, at, d);
        checks++; if (d !== 32'h11AA3344) begin errors++; $display("FAIL strobe_rd got=%h exp=11aa3344", d); end
    endtask

    task automatic test_fill();
        bit prev_dok = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b1, 1'b0, (i % 2 == 0) ? 32'h40 : 32'h80, 4'h0, 32'h0);
            checks++; if (obs_aok !== exp_aok) begin errors++; $display("FAIL fill_aok cyc=%0d got=%b exp=%b", smp_cyc, obs_aok, exp_aok); end
            checks++; if (obs_dok !== exp_dok) begin errors++; $display("FAIL fill_dok cyc=%0d got=%b exp=%b", smp_cyc, obs_dok, exp_dok); end
            if (exp_is_rd) begin
                checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL fill_order got=%h exp=%h", obs_rdata, exp_rdata); end
            end
`ifndef SRAM_RSP_RAND_DELAY_EN
            if (i < 2 || prev_dok) begin
                checks++; if (obs_aok !== 1'b1) begin errors++; $display("FAIL fill_reassert i=%0d got=%b exp=1", i, obs_aok); end
            end
`endif
            prev_dok = obs_dok;
        end
        req = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) run_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        resp_q.delete(); resp_at.delete();
    endtask

    task automatic test_read_before_write();
        bit ok1, ok2, f; int acc, at; logic [31:0] d;
        issue(1'b1, 32'h100, 4'hF, 32'h5, ok1, acc); wait_resp(f, at, d);
        issue(1'b0, 32'h100, 4'h0, 32'h0, ok1, acc);
        issue(1'b1, 32'h100, 4'hF, 32'h9, ok2, acc);
        wait_resp(f, at, d);
        checks++; if (!ok1 || !ok2 || d !== 32'h5) begin errors++; $display("FAIL rbw_old got=%h exp=5", d); end
        wait_resp(f, at, d);
        issue(1'b0, 32'h100, 4'h0, 32'h0, ok1, acc); wait_resp(f, at, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL rbw_new got=%h exp=9", d); end
    endtask

    task automatic test_alias();
        bit ok, f; int acc, at; logic [31:0] d;
        issue(1'b1, 32'h1004, 4'hF, 32'h77, ok, acc); wait_resp(f, at, d);
        issue(1'b0, 32'h0004, 4'h0, 32'h0, ok, acc); wait_resp(f, at, d);
        checks++; if (d !== 32'h77) begin errors++; $display("FAIL alias got=%h exp=77", d); end
        checks++; if (!f || at - acc < L || at - acc > LAT_MAX) begin
            errors++; $display("FAIL alias_latency got=%0d exp=%0d..%0d", at - acc, L, LAT_MAX); end
    endtask

    task automatic test_reset_midflight();
        bit ok, f; int acc, at; logic [31:0] d;
        for (int i = 0; i < 20 && q.size() < 2; i++) run_cycle(1'b1, 1'b0, 32'h80, 4'h0, 32'h0);
        req = 1'b0;
        resetn = 1'b0;
        #2;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL mid_rst_aok got=%b exp=1", addr_ok); end
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL mid_rst_dok got=%b exp=0", data_ok); end
        @(posedge clk); #1;
        resetn = 1'b1;
        q.delete(); resp_q.delete(); resp_at.delete();
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            checks++; if (obs_dok !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped cyc=%0d got=%b exp=0", smp_cyc, obs_dok); end
        end
        issue(1'b0, 32'h40, 4'h0, 32'h0, ok, acc); wait_resp(f, at, d);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_rst_mem got=%h exp=deadbeef", d); end
    endtask

    task automatic test_random();
        int pool [8] = '{3, 17, 100, 300, 511, 512, 777, 1023};
        bit ok, f; int acc, at, p; logic [31:0] d, a;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 32'(pool[i]) << 2, 4'hF, $urandom(), ok, acc);
            wait_resp(f, at, d);
        end
        resp_q.delete(); resp_at.delete();
        for (int i = 0; i < 300; i++) begin
            p = $urandom_range(0, 7);
            a = ($urandom() << (AW + 2)) | (32'(pool[p]) << 2) | ($urandom() & 32'h3);
            run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a, 4'($urandom()), $urandom());
            checks++; if (obs_aok !== exp_aok) begin errors++; $display("FAIL rnd_aok cyc=%0d got=%b exp=%b", smp_cyc, obs_aok, exp_aok); end
            checks++; if (obs_dok !== exp_dok) begin errors++; $display("FAIL rnd_dok cyc=%0d got=%b exp=%b", smp_cyc, obs_dok, exp_dok); end
            if (exp_is_rd) begin
                checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", smp_cyc, obs_rdata, exp_rdata); end
            end
        end
        req = 1'b0;
        for (int i = 0; i < 60 && q.size() > 0; i++) run_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain left=%0d exp=0", q.size()); end
        resp_q.delete(); resp_at.delete();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; head_start = 0;
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_fill();
        test_read_before_write();
        test_alias();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
